// File: rtl/score_display_ctrl.sv
// Saturating BCD score with digit-serial high-score compare at game over.
// Display digits are shadowed once per frame, with leading zeros blanked.
module score_display_ctrl #(
  parameter int         H_TOT      = 800,
  parameter int         V_TOT      = 525,
  parameter int         N_DIGITS   = 4,
  parameter int         V_LATCH    = 480,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic [$clog2(H_TOT)-1:0]  iCountH,
  input  logic [$clog2(V_TOT)-1:0]  iCountV,
  input  logic                      iScoreInc,
  input  logic                      iClear,
  input  logic                      iGameOver,
  output logic [4*N_DIGITS-1:0]     oScoreDigits,
  output logic [4*N_DIGITS-1:0]     oHighDigits,
  output logic                      oNewHigh,
  output logic                      oSat,
  output logic                      oBusy
);

  localparam int DW = 4 * N_DIGITS;
  localparam int VW = $clog2(V_TOT);
  localparam int KW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DW-1:0] DISP_RST = {{(N_DIGITS-1){BLANK_CODE}}, 4'h0};

  typedef enum logic [1:0] {PLAY, CMP, UPD, OVER} state_t;

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_reg, k_next;
  logic [DW-1:0]   score_reg, score_next;
  logic [DW-1:0]   high_reg, high_next;
  logic            new_high_reg, new_high_next;
  logic            pend_reg, pend_next;
  logic            go_prev_reg;
  logic [DW-1:0]   score_disp_reg, high_disp_reg;
  logic [N_DIGITS-1:0] nine;
  logic            sat;
  logic            go_edge;
  logic            latch;
  logic [3:0]      score_k, high_k;

  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] d);
    logic carry;
    carry   = 1'b1;
    bcd_inc = d;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (d[i*4 +: 4] == 4'd9) begin
          bcd_inc[i*4 +: 4] = 4'd0;
        end else begin
          bcd_inc[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  // Digits above the first nonzero one become blank; the LSD always shows.
  function automatic logic [DW-1:0] blank_lz(input logic [DW-1:0] d);
    logic lead;
    lead     = 1'b1;
    blank_lz = d;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      if (lead && d[i*4 +: 4] == 4'd0) begin
        blank_lz[i*4 +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  endfunction

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nine
      assign nine[gi] = (score_reg[gi*4 +: 4] == 4'd9);
    end
  endgenerate

  assign sat     = &nine;
  assign go_edge = iGameOver & ~go_prev_reg;
  assign latch   = (iCountH == '0) && (iCountV == VW'(V_LATCH));
  assign score_k = score_reg[{k_reg, 2'b00} +: 4];
  assign high_k  = high_reg[{k_reg, 2'b00} +: 4];

  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    score_next    = score_reg;
    high_next     = high_reg;
    new_high_next = new_high_reg;
    pend_next     = pend_reg;
    case (state_reg)
      PLAY: begin
        // Clear beats both increment and a coincident game-over edge.
        if (iClear) begin
          score_next = '0;
        end else begin
          if (go_edge) begin
            state_next = CMP;
            k_next     = KW'(N_DIGITS - 1);
          end
          if (iScoreInc && !sat) begin
            score_next = bcd_inc(score_reg);
          end
        end
      end
      CMP: begin
        if (iClear) pend_next = 1'b1;
        if (score_k > high_k) begin
          state_next = UPD;
        end else if (score_k < high_k || k_reg == '0) begin
          state_next = OVER;
        end else begin
          k_next = k_reg - 1'b1;
        end
      end
      UPD: begin
        if (iClear) pend_next = 1'b1;
        high_next     = score_reg;
        new_high_next = 1'b1;
        state_next    = OVER;
      end
      OVER: begin
        if (iClear || pend_reg) begin
          score_next    = '0;
          new_high_next = 1'b0;
          pend_next     = 1'b0;
          state_next    = PLAY;
        end
      end
      default: state_next = PLAY;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_reg      <= PLAY;
      k_reg          <= '0;
      score_reg      <= '0;
      high_reg       <= '0;
      new_high_reg   <= 1'b0;
      pend_reg       <= 1'b0;
      go_prev_reg    <= 1'b0;
      score_disp_reg <= DISP_RST;
      high_disp_reg  <= DISP_RST;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      score_reg    <= score_next;
      high_reg     <= high_next;
      new_high_reg <= new_high_next;
      pend_reg     <= pend_next;
      go_prev_reg  <= iGameOver;
      if (latch) begin
        score_disp_reg <= blank_lz(score_reg);
        high_disp_reg  <= blank_lz(high_reg);
      end
    end
  end

  assign oScoreDigits = score_disp_reg;
  assign oHighDigits  = high_disp_reg;
  assign oNewHigh     = new_high_reg;
  assign oSat         = sat;
  assign oBusy        = (state_reg == CMP) || (state_reg == UPD);

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: decimal reference model, display scoreboard
// filled at each latch line, and direct checks of busy/new-high/saturation.
module tb_score_display_ctrl;

  localparam int H  = 16;
  localparam int V  = 12;
  localparam int N  = 4;
  localparam int VL = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch, cv;
  logic        inc, clr, go;
  logic [15:0] sd, hd;
  logic        nh, sat, busy;

  int checks = 0;
  int errors = 0;
  int m_score = 0;
  int m_high  = 0;
  int latch_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  score_display_ctrl #(
    .H_TOT(H), .V_TOT(V), .N_DIGITS(N), .V_LATCH(VL), .BLANK_CODE(4'hF)
  ) dut (
    .iClk(clk), .iRstN(rst_n), .iCountH(ch), .iCountV(cv),
    .iScoreInc(inc), .iClear(clr), .iGameOver(go),
    .oScoreDigits(sd), .oHighDigits(hd), .oNewHigh(nh), .oSat(sat), .oBusy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal value -> expected display nibbles (digits above the value's magnitude are F).
  function automatic logic [15:0] disp(input int val);
    int p;
    p = 1;
    disp = '0;
    for (int i = 0; i < N; i++) begin
      disp[i*4 +: 4] = (i > 0 && val < p) ? 4'hF : 4'((val / p) % 10);
      p = p * 10;
    end
  endfunction

  // Busy cycles: one per compared digit from the MSD, plus one for the update on a win.
  function automatic int exp_busy(input int s, input int h);
    int p, ds, dh;
    p = 1000;
    for (int k = N - 1; k >= 0; k--) begin
      ds = (s / p) % 10;
      dh = (h / p) % 10;
      if (ds > dh) return N - k + 1;
      if (ds < dh) return N - k;
      p = p / 10;
    end
    return N;
  endfunction

  initial begin
    ch = '0;
    cv = '0;
    forever begin
      @(negedge clk);
      if (ch == 4'(H - 1)) begin
        ch = '0;
        cv = (cv == 4'(V - 1)) ? 4'd0 : cv + 4'd1;
      end else begin
        ch = ch + 4'd1;
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && ch == 4'd0 && cv == 4'(VL)) begin
        exp_q.push_back({disp(m_score), disp(m_high)});
        @(negedge clk);
        e = exp_q.pop_front();
        if (rst_n === 1'b1) begin
          $display("latch %0d: score=%h high=%h", latch_cnt, sd, hd);
          check("disp_score", {16'h0, sd}, {16'h0, e[31:16]});
          check("disp_high", {16'h0, hd}, {16'h0, e[15:0]});
          latch_cnt++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic model_inc();
    if (m_score < 9999) m_score++;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inc = 1'b1;
      if (i > 0) model_inc();
    end
    @(negedge clk);
    inc = 1'b0;
    model_inc();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_score = 0;
  endtask

  task automatic sync_safe();
    for (int i = 0; i < 400 && cv != 4'd1; i++) @(negedge clk);
  endtask

  task automatic wait_latch();
    int start;
    start = latch_cnt;
    for (int i = 0; i < 500 && latch_cnt == start; i++) @(negedge clk);
    check("latch_seen", {31'h0, latch_cnt != start}, 32'd1);
  endtask

  task automatic do_game(input bit clr_mid, input string tag);
    int cnt, eb;
    bit win;
    sync_safe();
    eb  = exp_busy(m_score, m_high);
    win = (m_score > m_high);
    cnt = 0;
    @(negedge clk);
    go = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
      clr = clr_mid && (cnt == 1);
    end
    clr = 1'b0;
    go  = 1'b0;
    $display("game %s: score=%0d high=%0d busy_cycles=%0d", tag, m_score, m_high, cnt);
    check({tag, "_busy"}, cnt, eb);
    if (win) m_high = m_score;
    if (clr_mid) begin
      @(negedge clk);
      @(negedge clk);
      m_score = 0;
      check({tag, "_newhigh"}, {31'h0, nh}, 32'd0);
      check({tag, "_idle"}, {31'h0, busy}, 32'd0);
    end else begin
      check({tag, "_newhigh"}, {31'h0, nh}, {31'h0, win});
    end
  endtask

  initial begin
    int bsum;
    rst_n = 1'b0;
    inc = 1'b0;
    clr = 1'b0;
    go  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_newhigh", {31'h0, nh}, 32'd0);
    check("rst_sat", {31'h0, sat}, 32'd0);
    check("rst_score", {16'h0, sd}, 32'h0000FFF0);
    check("rst_high", {16'h0, hd}, 32'h0000FFF0);
    rst_n = 1'b1;
    wait_latch();

    pulse_inc(9);
    pulse_inc(1);
    wait_latch();

    pulse_inc(110);
    do_game(1'b0, "first");
    do_clear();
    check("clear_newhigh", {31'h0, nh}, 32'd0);

    pulse_inc(125);
    do_game(1'b0, "win125");
    wait_latch();
    do_clear();

    pulse_inc(125);
    do_game(1'b0, "tie");
    do_clear();

    pulse_inc(99);
    do_game(1'b0, "lose");
    do_clear();

    pulse_inc(130);
    do_game(1'b1, "pend");
    pulse_inc(1);
    wait_latch();

    @(negedge clk);
    clr = 1'b1;
    inc = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    inc = 1'b0;
    m_score = 0;
    wait_latch();

    pulse_inc(7);
    sync_safe();
    @(negedge clk);
    clr = 1'b1;
    go  = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_score = 0;
    bsum = 0;
    repeat (4) begin
      @(negedge clk);
      bsum += int'(busy);
    end
    go = 1'b0;
    check("clr_go_nobusy", bsum, 0);
    wait_latch();

    pulse_inc(9998);
    check("sat_9998", {31'h0, sat}, 32'd0);
    pulse_inc(3);
    check("sat_9999", {31'h0, sat}, 32'd1);
    wait_latch();

    sync_safe();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    check("midcmp_busy", {31'h0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'h0, busy}, 32'd0);
    check("arst_sat", {31'h0, sat}, 32'd0);
    check("arst_newhigh", {31'h0, nh}, 32'd0);
    check("arst_score", {16'h0, sd}, 32'h0000FFF0);
    check("arst_high", {16'h0, hd}, 32'h0000FFF0);
    m_score = 0;
    m_high  = 0;
    go = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_latch();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
